sender_burst_ctrl: RTL and testbench

- Parametrised next-generation sender controller with an internal word buffer.
- Accepts words from the host while idle; on start, streams the stored words in write order to the downstream serializer using a Transmit/Ready handshake.
- Adds configurable width and depth, loop (continuous) mode, abort, clear and status flags.
- Sits between the host write interface and the SDR serializer.

---
 rtl/sender_pkg.sv | 20 ++
 rtl/sender_buf.sv | 26 ++
 rtl/sender_burst_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sender_burst_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sender_pkg.sv
// Shared types and defaults for the burst sender controller and its word buffer.
`timescale 1ns/1ps
package sender_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_DEPTH    = 16;
    localparam int unsigned DEF_TX_PULSE = 3;
    // Pulse-width counter is sized for the full 1..15 TX_PULSE range
    localparam int unsigned PCNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LATCH,
        PULSE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/sender_buf.sv
// DEPTH x DATA_W word store: one synchronous write port, one synchronous read port.
`timescale 1ns/1ps
module sender_buf #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; read data lags the address by one cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sender_burst_ctrl.sv
// Buffers host words while idle, then streams them to the SDR serializer
// with a Transmit/Ready handshake; supports loop mode, abort and clear.
`timescale 1ns/1ps
module sender_burst_ctrl
    import sender_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter int unsigned TX_PULSE = DEF_TX_PULSE
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              start,
    input  logic              abort,
    input  logic              clr,
    input  logic              loop_mode,
    input  logic              Ready,
    output logic              Transmit,
    output logic [DATA_W-1:0] sdrDataIn,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] rd_ptr;
    logic              loop_q;
    logic [PCNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] rd_data;

    logic last_word_c;
    logic pulse_end_c;
    logic wr_accept_c;
    logic cnt_clr_c;
    logic ovf_set_c;
    logic burst_start_c;
    logic data_latch_c;
    logic pulse_run_c;
    logic ptr_inc_c;
    logic ptr_wrap_c;
    logic done_set_c;

    assign last_word_c = (CNT_W'(rd_ptr) + CNT_W'(1)) >= count;
    assign pulse_end_c = (state == PULSE) && (pulse_cnt == PCNT_W'(TX_PULSE - 1));

    sender_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_accept_c),
        .wr_addr (count[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every non-idle transition
    always_comb begin
        state_next = state;
        if (state != IDLE && abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      if (!clr && !wr_en && start && !empty) state_next = RD;
                RD:        state_next = LATCH;
                LATCH:     if (Ready) state_next = PULSE;
                PULSE:     if (pulse_end_c) state_next = WAIT_ACK;
                WAIT_ACK:  if (!Ready) state_next = WAIT_DONE;
                WAIT_DONE: begin
                    if (Ready) begin
                        state_next = (last_word_c && !loop_q) ? IDLE : RD;
                    end
                end
                default:   state_next = IDLE;
            endcase
        end
    end

    // Datapath strobes decoded from state; idle priority is clr > wr_en > start
    always_comb begin
        wr_accept_c   = 1'b0;
        cnt_clr_c     = 1'b0;
        ovf_set_c     = 1'b0;
        burst_start_c = 1'b0;
        data_latch_c  = 1'b0;
        pulse_run_c   = 1'b0;
        ptr_inc_c     = 1'b0;
        ptr_wrap_c    = 1'b0;
        done_set_c    = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    cnt_clr_c = 1'b1;
                end else if (wr_en) begin
                    if (full) ovf_set_c = 1'b1;
                    else      wr_accept_c = 1'b1;
                end else if (start && !empty) begin
                    burst_start_c = 1'b1;
                end
            end
            LATCH:     data_latch_c = !abort;
            PULSE:     pulse_run_c  = !abort;
            WAIT_DONE: begin
                if (Ready && !abort) begin
                    if (!last_word_c)  ptr_inc_c  = 1'b1;
                    else if (loop_q)   ptr_wrap_c = 1'b1;
                    else               done_set_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        count_next = count;
        if (cnt_clr_c) begin
            count_next = '0;
        end else if (wr_accept_c) begin
            count_next = count + CNT_W'(1);
        end
    end

    // Registered pointers, flags and serializer-facing outputs
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            rd_ptr    <= '0;
            loop_q    <= 1'b0;
            pulse_cnt <= '0;
            sdrDataIn <= '0;
            Transmit  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            count    <= count_next;
            full     <= (count_next == CNT_W'(DEPTH));
            empty    <= (count_next == '0);
            done     <= done_set_c;
            overflow <= ovf_set_c;
            Transmit <= (state_next == PULSE);
            busy     <= (state_next != IDLE);
            if (burst_start_c) begin
                loop_q <= loop_mode;
            end
            if (burst_start_c || ptr_wrap_c) begin
                rd_ptr <= '0;
            end else if (ptr_inc_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (pulse_run_c && !pulse_end_c) begin
                pulse_cnt <= pulse_cnt + PCNT_W'(1);
            end else begin
                pulse_cnt <= '0;
            end
            if (data_latch_c) begin
                sdrDataIn <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_sender_burst_ctrl.sv
// Self-checking bench for sender_burst_ctrl: idle-op vector table, directed
// multi-cycle sequences and randomized bursts against a word-queue model.
`timescale 1ns/1ps
module tb_sender_burst_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TXP   = 3;

    logic          clk;
    logic          Reset;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          start;
    logic          abort;
    logic          clr;
    logic          loop_mode;
    logic          Ready;
    logic          Transmit;
    logic [DW-1:0] sdrDataIn;
    logic [4:0]    count;
    logic          full;
    logic          empty;
    logic          busy;
    logic          done;
    logic          overflow;

    sender_burst_ctrl #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .TX_PULSE (TXP)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .start     (start),
        .abort     (abort),
        .clr       (clr),
        .loop_mode (loop_mode),
        .Ready     (Ready),
        .Transmit  (Transmit),
        .sdrDataIn (sdrDataIn),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Serializer model: drops Ready one cycle after seeing Transmit, busy for ser_busy cycles
    logic ser_auto;
    logic ser_ready;
    logic ready_man;
    int   ser_busy;
    assign Ready = ser_auto ? ser_ready : ready_man;

    initial begin
        ser_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (Transmit && ser_ready) begin
                @(posedge clk); #2;
                ser_ready = 1'b0;
                repeat (ser_busy) @(posedge clk);
                #2;
                ser_ready = 1'b1;
            end
        end
    end

    // Monitor: words carried by each Transmit pulse, pulse widths, done/overflow pulses
    logic [DW-1:0] tx_words[$];
    int            tx_widths[$];
    int            done_cnt;
    int            ovf_cnt;
    int            cur_w;
    logic          tx_prev;

    initial begin
        tx_prev = 1'b0;
        cur_w   = 0;
        forever begin
            @(posedge clk); #3;
            if (Transmit && !tx_prev) begin
                tx_words.push_back(sdrDataIn);
                cur_w = 1;
            end else if (Transmit) begin
                cur_w++;
            end
            if (!Transmit && tx_prev) tx_widths.push_back(cur_w);
            tx_prev = Transmit;
            if (done)     done_cnt++;
            if (overflow) ovf_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        tx_words.delete();
        tx_widths.delete();
        done_cnt = 0;
        ovf_cnt  = 0;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic lm);
        start     = 1'b1;
        loop_mode = lm;
        tick();
        start     = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000; i++) begin
            if (!busy) break;
            tick();
        end
        chk("burst_end", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic          wr_en;
        logic          clr;
        logic          start;
        logic          abort;
        logic [DW-1:0] data;
        int            exp_count;
        logic          exp_empty;
        logic          exp_busy;
    } vec_t;

    vec_t          vecs[8];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
    logic [DW-1:0] d;
    int            exp_ovf;
    int            rises;
    int            k;
    logic          prev_tx;
    logic          seen;

    initial begin
        // Idle-operation table: priority clr > wr_en > start, abort ignored when idle
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h2222, 2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h5555, 0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h3333, 1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h4444, 1, 1'b0, 1'b0};

        Reset = 1'b1; wr_data = '0; wr_en = 1'b0; start = 1'b0; abort = 1'b0;
        clr = 1'b0; loop_mode = 1'b0; ready_man = 1'b1; ser_auto = 1'b0; ser_busy = 4;
        clear_mon();
        tick(); tick();
        chk("rst_transmit", 32'(Transmit), 32'd0);
        chk("rst_data", 32'(sdrDataIn), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            wr_en = vecs[i].wr_en; clr = vecs[i].clr; start = vecs[i].start;
            abort = vecs[i].abort; wr_data = vecs[i].data;
            tick();
            wr_en = 1'b0; clr = 1'b0; start = 1'b0; abort = 1'b0;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
        end

        // Fill to DEPTH, then one more write must be dropped with a single overflow pulse
        model_q.delete();
        model_q.push_back(16'h4444);
        for (int i = 1; i < 16; i++) begin
            d = 16'($urandom);
            model_q.push_back(d);
            wr(d);
        end
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf_idle", 32'(overflow), 32'd0);
        wr(16'hDEAD);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        tick();
        chk("ovf_single", 32'(overflow), 32'd0);
        chk("ovf_count", 32'(count), 32'd16);
        clear_mon();
        ser_auto = 1'b1; ser_busy = 4;
        do_start(1'b0);
        wait_idle();
        repeat (3) tick();
        chk("full_nwords", 32'(tx_words.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("full_w%0d", i), (i < tx_words.size()) ? 32'(tx_words[i]) : 32'hFFFF_FFFF, 32'(model_q[i]));
        chk("full_done", 32'(done_cnt), 32'd1);

        // Basic three-word burst with a slow serializer
        do_clr();
        wr(16'hA001); wr(16'hA002); wr(16'hA003);
        ser_busy = 20;
        clear_mon();
        do_start(1'b0);
        wait_idle();
        repeat (3) tick();
        chk("basic_nwords", 32'(tx_words.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("basic_w%0d", i), (i < tx_words.size()) ? 32'(tx_words[i]) : 32'hFFFF_FFFF, 32'hA001 + 32'(i));
            chk($sformatf("basic_width%0d", i), (i < tx_widths.size()) ? 32'(tx_widths[i]) : 32'hFFFF_FFFF, 32'(TXP));
        end
        chk("basic_done", 32'(done_cnt), 32'd1);
        chk("basic_count", 32'(count), 32'd3);

        // Priority, then LATCH hold while Ready is low
        ser_auto = 1'b0; ready_man = 1'b1;
        do_clr();
        wr(16'hBEEF);
        wr_en = 1'b1; wr_data = 16'hCAFE; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("prio_count", 32'(count), 32'd2);
        chk("prio_busy", 32'(busy), 32'd0);
        ready_man = 1'b0;
        do_start(1'b0);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            chk("latch_hold_tx", 32'(Transmit), 32'd0);
            chk("latch_hold_busy", 32'(busy), 32'd1);
            tick();
        end
        ready_man = 1'b1;
        tick();
        chk("latch_release_tx", 32'(Transmit), 32'd1);
        chk("latch_release_data", 32'(sdrDataIn), 32'hBEEF);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("prio_abort_tx", 32'(Transmit), 32'd0);
        chk("prio_abort_busy", 32'(busy), 32'd0);

        // Start-to-Transmit latency and pulse width with Ready already high
        do_start(1'b0);
        chk("lat_n0", 32'(Transmit), 32'd0);
        tick();
        chk("lat_n1", 32'(Transmit), 32'd0);
        tick();
        chk("lat_n2", 32'(Transmit), 32'd1);
        chk("lat_data", 32'(sdrDataIn), 32'hBEEF);
        tick();
        chk("lat_n3", 32'(Transmit), 32'd1);
        tick();
        chk("lat_n4", 32'(Transmit), 32'd1);
        tick();
        chk("lat_n5", 32'(Transmit), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("lat_abort_busy", 32'(busy), 32'd0);

        // Loop mode, aborted in the first cycle of the fifth pulse
        do_clr();
        w0 = 16'($urandom); w1 = 16'($urandom);
        wr(w0); wr(w1);
        ser_auto = 1'b1; ser_busy = 6;
        clear_mon();
        do_start(1'b1);
        rises = 0; prev_tx = 1'b0;
        for (int i = 0; i < 2000 && rises < 5; i++) begin
            tick();
            if (Transmit && !prev_tx) rises++;
            prev_tx = Transmit;
        end
        chk("loop_fifth_pulse", 32'(rises), 32'd5);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("loop_abort_tx", 32'(Transmit), 32'd0);
        chk("loop_abort_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("loop_no_done", 32'(done_cnt), 32'd0);
        chk("loop_nwords", 32'(tx_words.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("loop_w%0d", i), (i < tx_words.size()) ? 32'(tx_words[i]) : 32'hFFFF_FFFF, 32'((i % 2 == 0) ? w0 : w1));
        chk("loop_count", 32'(count), 32'd2);
        repeat (30) tick();

        // Asynchronous reset during the second Transmit cycle
        do_clr();
        wr(16'h1234); wr(16'h5678);
        do_start(1'b0);
        for (int i = 0; i < 200 && !Transmit; i++) tick();
        tick();
        chk("rstmid_pre_tx", 32'(Transmit), 32'd1);
        #3 Reset = 1'b1;
        #1;
        chk("rstmid_tx", 32'(Transmit), 32'd0);
        chk("rstmid_count", 32'(count), 32'd0);
        chk("rstmid_data", 32'(sdrDataIn), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        do_start(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy || Transmit) seen = 1'b1;
            tick();
        end
        chk("rstmid_start_ignored", 32'(seen), 32'd0);
        repeat (30) tick();

        // Clear then start on an empty buffer
        wr(16'h0A0A); wr(16'h0B0B);
        chk("clr_pre_count", 32'(count), 32'd2);
        do_clr();
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        do_start(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy || Transmit) seen = 1'b1;
            tick();
        end
        chk("clr_start_ignored", 32'(seen), 32'd0);

        // Randomized append/clear/burst rounds against a word-queue model
        model_q.delete();
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_clr();
                model_q.delete();
            end
            k = $urandom_range(0, 20);
            exp_ovf = 0;
            clear_mon();
            for (int j = 0; j < k; j++) begin
                d = 16'($urandom);
                wr(d);
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else exp_ovf++;
                repeat ($urandom_range(0, 1)) tick();
            end
            tick(); tick();
            chk($sformatf("rnd%0d_count", it), 32'(count), 32'(model_q.size()));
            chk($sformatf("rnd%0d_full", it), 32'(full), 32'(model_q.size() == DEPTH));
            chk($sformatf("rnd%0d_ovf", it), 32'(ovf_cnt), 32'(exp_ovf));
            ser_busy = $urandom_range(4, 12);
            clear_mon();
            do_start(1'b0);
            if (model_q.size() > 0) wait_idle();
            else repeat (5) tick();
            repeat (3) tick();
            chk($sformatf("rnd%0d_nwords", it), 32'(tx_words.size()), 32'(model_q.size()));
            for (int i = 0; i < model_q.size(); i++)
                chk($sformatf("rnd%0d_w%0d", it, i), (i < tx_words.size()) ? 32'(tx_words[i]) : 32'hFFFF_FFFF, 32'(model_q[i]));
            for (int i = 0; i < tx_widths.size(); i++)
                chk($sformatf("rnd%0d_width%0d", it, i), 32'(tx_widths[i]), 32'(TXP));
            chk($sformatf("rnd%0d_done", it), 32'(done_cnt), 32'(model_q.size() > 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
